spi_dcs_master: RTL and testbench

SPI_DCS_MASTER -- requirements
Module: spi_dcs_master

---
 rtl/spi_dcs_pkg.sv | 19 +
 rtl/spi_dcs_clkgen.sv | 37 +++
 rtl/spi_dcs_master.sv | 166 ++++++++++++++++
 tb/tb_spi_dcs_master.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_dcs_pkg.sv
// Shared definitions for the dual-chip-select SPI master: FSM state encoding
// and default geometry constants.
package spi_dcs_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        A_SETUP = 3'd1,
        A_SHIFT = 3'd2,
        A_GAP   = 3'd3,
        D_SETUP = 3'd4,
        D_SHIFT = 3'd5,
        D_END   = 3'd6
    } state_e;

    localparam int DEF_WIDTH_ADDR = 8;
    localparam int DEF_WIDTH_DATA = 16;
    localparam int DEF_CLK_DIV    = 4;

endpackage

// File: rtl/spi_dcs_clkgen.sv
// SCL half-period divider: reloads while load_i is high and pulses tick_o
// on the last clk cycle of every CLK_DIV-cycle half period.
module spi_dcs_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Auto-reload at zero so back-to-back half periods need no extra load.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i || (cnt_q == '0)) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !load_i && (cnt_q == '0);

endmodule

// File: rtl/spi_dcs_master.sv
// SPI mode-0 master with separate address and data chip selects.
// Optional SPI_DCS_MASTER_SKIP_ADDR_EN adds skip_addr to bypass the address phase.
module spi_dcs_master
    import spi_dcs_pkg::*;
#(
    parameter int width_addr = DEF_WIDTH_ADDR,
    parameter int width_data = DEF_WIDTH_DATA,
    parameter int CLK_DIV    = DEF_CLK_DIV
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
`ifdef SPI_DCS_MASTER_SKIP_ADDR_EN
    input  logic                  skip_addr,
`endif
    input  logic [width_addr-1:0] addr_in,
    input  logic [width_data-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic [width_data-1:0] rdata,
    output logic                  spi_scl,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic                  spi_cs_addr,
    output logic                  spi_cs_data
);

    localparam int MAXW = (width_addr > width_data) ? width_addr : width_data;
    localparam int BW   = $clog2(MAXW + 1);

    state_e                state_q, state_d;
    logic                  scl_q, scl_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [width_addr-1:0] addr_q, addr_d;
    logic [width_data-1:0] data_q, data_d;
    logic [width_data-1:0] rx_q, rx_d;
    logic [width_data-1:0] rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic                  tick;
    logic                  skip;

`ifdef SPI_DCS_MASTER_SKIP_ADDR_EN
    assign skip = skip_addr;
`else
    assign skip = 1'b0;
`endif

    spi_dcs_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q == IDLE),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        scl_d   = scl_q;
        bit_d   = bit_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = addr_in;
                    data_d  = wdata;
                    state_d = skip ? D_SETUP : A_SETUP;
                end
            end
            A_SETUP: begin
                if (tick) begin
                    state_d = A_SHIFT;
                    scl_d   = 1'b1;
                    bit_d   = '0;
                end
            end
            A_SHIFT: begin
                if (tick) begin
                    if (scl_q) begin
                        scl_d  = 1'b0;
                        addr_d = addr_q << 1;
                        bit_d  = bit_q + 1'b1;
                    end else if (bit_q == BW'(width_addr)) begin
                        state_d = A_GAP;
                    end else begin
                        scl_d = 1'b1;
                    end
                end
            end
            A_GAP: begin
                if (tick) state_d = D_SETUP;
            end
            D_SETUP: begin
                if (tick) begin
                    state_d = D_SHIFT;
                    scl_d   = 1'b1;
                    bit_d   = '0;
                end
            end
            D_SHIFT: begin
                if (tick) begin
                    // MISO captured on the final clk of the SCL-high half.
                    if (scl_q) begin
                        scl_d  = 1'b0;
                        rx_d   = (rx_q << 1) | width_data'(spi_miso);
                        data_d = data_q << 1;
                        bit_d  = bit_q + 1'b1;
                    end else if (bit_q == BW'(width_data)) begin
                        state_d = D_END;
                    end else begin
                        scl_d = 1'b1;
                    end
                end
            end
            D_END: begin
                if (tick) begin
                    state_d = IDLE;
                    rdata_d = rx_q;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            scl_q   <= 1'b0;
            bit_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            scl_q   <= scl_d;
            bit_q   <= bit_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        spi_mosi = 1'b0;
        unique case (state_q)
            A_SETUP, A_SHIFT: spi_mosi = addr_q[width_addr-1];
            D_SETUP, D_SHIFT: spi_mosi = data_q[width_data-1];
            default:          spi_mosi = 1'b0;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign spi_scl     = scl_q;
    assign spi_cs_addr = !((state_q == A_SETUP) || (state_q == A_SHIFT));
    assign spi_cs_data = !((state_q == D_SETUP) || (state_q == D_SHIFT));

endmodule

// File: tb/tb_spi_dcs_master.sv
// Directed bench for spi_dcs_master: default geometry plus a CLK_DIV=7, 4/8-bit instance.
`timescale 1ns/1ps
module tb_spi_dcs_master;

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default-geometry DUT
    logic        start = 1'b0;
    logic [7:0]  addr_in = '0;
    logic [15:0] wdata = '0;
    logic        busy, done, scl, mosi, miso, csa, csd;
    logic [15:0] rdata;
`ifdef SPI_DCS_MASTER_SKIP_ADDR_EN
    logic        skip_addr = 1'b0;
`endif

    // CLK_DIV=7, 4-bit address, 8-bit data DUT
    logic        start1 = 1'b0;
    logic [3:0]  addr1 = '0;
    logic [7:0]  wdata1 = '0;
    logic        busy1, done1, scl1, mosi1, miso1, csa1, csd1;
    logic [7:0]  rdata1;

    spi_dcs_master dut0 (
        .clk(clk), .rst(rst), .start(start),
`ifdef SPI_DCS_MASTER_SKIP_ADDR_EN
        .skip_addr(skip_addr),
`endif
        .addr_in(addr_in), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .spi_scl(scl), .spi_mosi(mosi), .spi_miso(miso),
        .spi_cs_addr(csa), .spi_cs_data(csd)
    );

    spi_dcs_master #(.width_addr(4), .width_data(8), .CLK_DIV(7)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
`ifdef SPI_DCS_MASTER_SKIP_ADDR_EN
        .skip_addr(1'b0),
`endif
        .addr_in(addr1), .wdata(wdata1), .busy(busy1), .done(done1), .rdata(rdata1),
        .spi_scl(scl1), .spi_mosi(mosi1), .spi_miso(miso1),
        .spi_cs_addr(csa1), .spi_cs_data(csd1)
    );

    // Slave for dut0: MISO bit index = number of SCL falls since CS_data fell
    logic [15:0] s_tx = '0;
    logic [7:0]  s_addr = '0;
    logic [15:0] s_dout = '0;
    int rises0 = 0, falls0 = 0, fbase0 = 0;
    always @(posedge scl) begin
        rises0++;
        if (!csa) s_addr = {s_addr[6:0], mosi};
        if (!csd) s_dout = {s_dout[14:0], mosi};
    end
    always @(negedge scl) falls0++;
    always @(negedge csd) fbase0 = falls0;
    assign miso = (falls0 - fbase0 < 16) ? s_tx[15 - (falls0 - fbase0)] : 1'b0;

    // Slave for dut1
    logic [7:0] s_tx1 = '0;
    logic [3:0] s_addr1 = '0;
    logic [7:0] s_dout1 = '0;
    int falls1 = 0, fbase1 = 0;
    always @(posedge scl1) begin
        if (!csa1) s_addr1 = {s_addr1[2:0], mosi1};
        if (!csd1) s_dout1 = {s_dout1[6:0], mosi1};
    end
    always @(negedge scl1) falls1++;
    always @(negedge csd1) fbase1 = falls1;
    assign miso1 = (falls1 - fbase1 < 8) ? s_tx1[7 - (falls1 - fbase1)] : 1'b0;

    // Protocol monitors, sampled just after each rising clk edge
    logic        scl_p = 1'b0, mosi_p = 1'b0;
    logic [15:0] rdata_p = '0;
    int viol = 0, csa_low = 0;
    logic lvl1_p = 1'b0;
    int run1 = 0, hi7 = 0, hibad = 0, lo7 = 0;
    always @(posedge clk) begin
        #1;
        if (!csa && !csd) viol++;
        if (scl_p && scl && (mosi !== mosi_p)) viol++;
        if ((rdata !== rdata_p) && !done && !rst) viol++;
        if (!csa) csa_low++;
        scl_p = scl; mosi_p = mosi; rdata_p = rdata;
        if (scl1 !== lvl1_p) begin
            if (lvl1_p) begin
                if (run1 == 7) hi7++; else hibad++;
            end else if (run1 == 7) begin
                lo7++;
            end
            run1 = 1;
            lvl1_p = scl1;
        end else begin
            run1++;
        end
    end

    task automatic xfer0(input logic [7:0] a, input logic [15:0] d, input logic [15:0] stx,
                         input int repulse, output int bcyc, output int dcnt);
        s_tx = stx; addr_in = a; wdata = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0; bcyc = 0; dcnt = 0;
        for (int i = 0; i < 1000; i++) begin
            if (busy) bcyc++;
            if (done) begin dcnt++; break; end
            start = (i == repulse);
            if (i == repulse) begin addr_in = ~a; wdata = ~d; end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (csa !== 1'b1)   begin bad++; $display("FAIL reset_cs_addr got=%b want=1", csa); end
        total++; if (csd !== 1'b1)   begin bad++; $display("FAIL reset_cs_data got=%b want=1", csd); end
        total++; if (scl !== 1'b0)   begin bad++; $display("FAIL reset_scl got=%b want=0", scl); end
        total++; if (mosi !== 1'b0)  begin bad++; $display("FAIL reset_mosi got=%b want=0", mosi); end
        total++; if (rdata !== 16'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0000", rdata); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int bcyc, dcnt, r0;
        r0 = rises0;
        xfer0(8'hA5, 16'h3C5A, 16'hBEEF, -1, bcyc, dcnt);
        total++; if (dcnt != 1)          begin bad++; $display("FAIL basic_done got=%0d want=1", dcnt); end
        total++; if (bcyc != 208)        begin bad++; $display("FAIL basic_busy got=%0d want=208", bcyc); end
        total++; if (s_addr !== 8'hA5)   begin bad++; $display("FAIL basic_addr got=%h want=a5", s_addr); end
        total++; if (s_dout !== 16'h3C5A) begin bad++; $display("FAIL basic_dout got=%h want=3c5a", s_dout); end
        total++; if (rdata !== 16'hBEEF) begin bad++; $display("FAIL basic_rdata got=%h want=beef", rdata); end
        total++; if (rises0 - r0 != 24)  begin bad++; $display("FAIL basic_rises got=%0d want=24", rises0 - r0); end
        @(negedge clk);
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL basic_done_width got=%b want=0", done); end
        total++; if (rdata !== 16'hBEEF) begin bad++; $display("FAIL basic_rdata_hold got=%h want=beef", rdata); end
    endtask

    task automatic test_busy_ignore;
        int bcyc, dcnt, r0, extra;
        r0 = rises0;
        xfer0(8'h3C, 16'h1234, 16'h5A5A, 50, bcyc, dcnt);
        total++; if (bcyc != 208)        begin bad++; $display("FAIL ign_busy got=%0d want=208", bcyc); end
        total++; if (rises0 - r0 != 24)  begin bad++; $display("FAIL ign_rises got=%0d want=24", rises0 - r0); end
        total++; if (s_addr !== 8'h3C)   begin bad++; $display("FAIL ign_addr got=%h want=3c", s_addr); end
        total++; if (s_dout !== 16'h1234) begin bad++; $display("FAIL ign_dout got=%h want=1234", s_dout); end
        total++; if (rdata !== 16'h5A5A) begin bad++; $display("FAIL ign_rdata got=%h want=5a5a", rdata); end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        total++; if (dcnt + extra != 1)  begin bad++; $display("FAIL ign_single_done got=%0d want=1", dcnt + extra); end
    endtask

    task automatic test_back_to_back;
        int n;
        s_tx = 16'h1111; addr_in = 8'h01; wdata = 16'h8000; start = 1'b1;
        n = 0;
        @(negedge clk);
        while (!done && n < 400) begin @(negedge clk); n++; end
        total++; if (done !== 1'b1)      begin bad++; $display("FAIL b2b_done1 got=%b want=1", done); end
        total++; if (rdata !== 16'h1111) begin bad++; $display("FAIL b2b_rdata1 got=%h want=1111", rdata); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL b2b_gap_busy got=%b want=0", busy); end
        s_tx = 16'h2222;
        @(negedge clk);
        start = 1'b0;
        total++; if (csa !== 1'b0)       begin bad++; $display("FAIL b2b_cs_addr got=%b want=0", csa); end
        total++; if (busy !== 1'b1)      begin bad++; $display("FAIL b2b_busy2 got=%b want=1", busy); end
        n = 0;
        while (!done && n < 400) begin @(negedge clk); n++; end
        total++; if (rdata !== 16'h2222) begin bad++; $display("FAIL b2b_rdata2 got=%h want=2222", rdata); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n;
        s_tx = 16'hF00F; addr_in = 8'h5A; wdata = 16'h0F0F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (csa !== 1'b1)       begin bad++; $display("FAIL rstmid_cs_addr got=%b want=1", csa); end
        total++; if (csd !== 1'b1)       begin bad++; $display("FAIL rstmid_cs_data got=%b want=1", csd); end
        total++; if (scl !== 1'b0)       begin bad++; $display("FAIL rstmid_scl got=%b want=0", scl); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        total++; if (rdata !== 16'h0)    begin bad++; $display("FAIL rstmid_rdata got=%h want=0000", rdata); end
        rst = 1'b0;
        n = 0;
        repeat (300) begin
            if (done || busy) n++;
            @(negedge clk);
        end
        total++; if (n != 0)             begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", n); end
    endtask

    task automatic test_div7;
        int bcyc, dcnt, h0, hb0, l0;
        h0 = hi7; hb0 = hibad; l0 = lo7;
        s_tx1 = 8'h81; addr1 = 4'h9; wdata1 = 8'hC3; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; bcyc = 0; dcnt = 0;
        for (int i = 0; i < 1000; i++) begin
            if (busy1) bcyc++;
            if (done1) begin dcnt++; break; end
            @(negedge clk);
        end
        total++; if (dcnt != 1)          begin bad++; $display("FAIL div7_done got=%0d want=1", dcnt); end
        total++; if (bcyc != 196)        begin bad++; $display("FAIL div7_busy got=%0d want=196", bcyc); end
        total++; if (rdata1 !== 8'h81)   begin bad++; $display("FAIL div7_rdata got=%h want=81", rdata1); end
        total++; if (s_addr1 !== 4'h9)   begin bad++; $display("FAIL div7_addr got=%h want=9", s_addr1); end
        total++; if (s_dout1 !== 8'hC3)  begin bad++; $display("FAIL div7_dout got=%h want=c3", s_dout1); end
        total++; if (hi7 - h0 != 12)     begin bad++; $display("FAIL div7_high7 got=%0d want=12", hi7 - h0); end
        total++; if (hibad - hb0 != 0)   begin bad++; $display("FAIL div7_high_bad got=%0d want=0", hibad - hb0); end
        total++; if (lo7 - l0 != 10)     begin bad++; $display("FAIL div7_low7 got=%0d want=10", lo7 - l0); end
    endtask

`ifdef SPI_DCS_MASTER_SKIP_ADDR_EN
    task automatic test_skip;
        int bcyc, dcnt, c0;
        c0 = csa_low;
        skip_addr = 1'b1;
        xfer0(8'hFF, 16'h0001, 16'hA55A, -1, bcyc, dcnt);
        skip_addr = 1'b0;
        total++; if (dcnt != 1)          begin bad++; $display("FAIL skip_done got=%0d want=1", dcnt); end
        total++; if (bcyc != 136)        begin bad++; $display("FAIL skip_busy got=%0d want=136", bcyc); end
        total++; if (csa_low - c0 != 0)  begin bad++; $display("FAIL skip_cs_addr got=%0d want=0", csa_low - c0); end
        total++; if (s_dout !== 16'h0001) begin bad++; $display("FAIL skip_dout got=%h want=0001", s_dout); end
        total++; if (rdata !== 16'hA55A) begin bad++; $display("FAIL skip_rdata got=%h want=a55a", rdata); end
    endtask
`endif

    task automatic test_protocol;
        total++; if (viol != 0) begin bad++; $display("FAIL protocol_violations got=%0d want=0", viol); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_busy_ignore;
        test_back_to_back;
        test_reset_mid;
        test_div7;
`ifdef SPI_DCS_MASTER_SKIP_ADDR_EN
        test_skip;
`endif
        test_protocol;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
